// File: rtl/mem_resp_if.sv
`default_nettype none
// ============================================================================
// mem_resp_if : request/response bundle between a multicycle core and mem_resp
// Revision    : 1.0
// ============================================================================
interface mem_resp_if;
   logic        MREQ;
   logic [31:0] MRA;
   logic        MWE;
   logic [31:0] MWD;
   logic [31:0] MRD;
   logic        MRDY;
   logic        MERR;

   modport master (
      output MREQ, MRA, MWE, MWD,
      input  MRD, MRDY, MERR
   );

   modport slave (
      input  MREQ, MRA, MWE, MWD,
      output MRD, MRDY, MERR
   );
endinterface
`default_nettype wire

// File: rtl/mem_resp.sv
`default_nettype none
// ============================================================================
// mem_resp : word memory answering core requests after WAIT_CYC wait states
//            Optional macro MEM_RESP_ALIGN_CHK_EN flags misaligned requests.
// Revision : 1.0
// ============================================================================
module mem_resp #(
   parameter int DEPTH_LOG2 = 8,
   parameter int WAIT_CYC   = 2
) (
   input wire logic  CLK,
   input wire logic  rst,
   mem_resp_if.slave bus
);
   localparam int         WORDS     = 1 << DEPTH_LOG2;
   localparam logic [3:0] WAIT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state;
   logic [3:0]            cnt;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic                  we_q;
   logic [31:0]           wd_q;
   logic [31:0]           mem [WORDS];

   logic                  accept;
   logic                  enter_resp;
   logic [DEPTH_LOG2-1:0] idx_eff;
   logic                  we_eff;
   logic [31:0]           wd_eff;
   logic                  do_write;
   logic [31:0]           rd_next;
   logic                  unused_addr;

   // With zero wait states the access happens on the accept edge itself, so
   // the live request fields stand in for the not-yet-captured ones.
   assign accept     = rst && (state == IDLE) && bus.MREQ;
   assign enter_resp = ((state == WAIT) && (cnt == 4'd0)) ||
                       (accept && (WAIT_CYC == 0));
   assign idx_eff    = accept ? bus.MRA[DEPTH_LOG2+1:2] : idx_q;
   assign we_eff     = accept ? bus.MWE : we_q;
   assign wd_eff     = accept ? bus.MWD : wd_q;

   assign unused_addr = ^{bus.MRA[31:DEPTH_LOG2+2], bus.MRA[1:0]};

`ifdef MEM_RESP_ALIGN_CHK_EN
   logic bad_q;
   logic bad_eff;
   assign bad_eff  = accept ? (bus.MRA[1:0] != 2'b00) : bad_q;
   assign do_write = enter_resp && we_eff && !bad_eff;
   assign rd_next  = bad_eff ? 32'h0 : mem[idx_eff];
`else
   assign do_write = enter_resp && we_eff;
   assign rd_next  = mem[idx_eff];
   assign bus.MERR = 1'b0;
`endif

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         idx_q    <= '0;
         we_q     <= 1'b0;
         wd_q     <= 32'h0;
         bus.MRD  <= 32'h0;
         bus.MRDY <= 1'b0;
`ifdef MEM_RESP_ALIGN_CHK_EN
         bad_q    <= 1'b0;
         bus.MERR <= 1'b0;
`endif
      end else begin
         bus.MRDY <= 1'b0;
`ifdef MEM_RESP_ALIGN_CHK_EN
         bus.MERR <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (bus.MREQ) begin
                  idx_q <= bus.MRA[DEPTH_LOG2+1:2];
                  we_q  <= bus.MWE;
                  wd_q  <= bus.MWD;
                  cnt   <= WAIT_INIT;
`ifdef MEM_RESP_ALIGN_CHK_EN
                  bad_q <= (bus.MRA[1:0] != 2'b00);
`endif
                  state <= (WAIT_CYC == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               // Strobe lands on the edge closing RESP, one cycle after the data.
               state    <= IDLE;
               bus.MRDY <= 1'b1;
`ifdef MEM_RESP_ALIGN_CHK_EN
               bus.MERR <= bad_q;
`endif
            end
            default: state <= IDLE;
         endcase

         if (enter_resp && !we_eff) begin
            bus.MRD <= rd_next;
         end
      end
   end

   // Storage is deliberately outside the reset domain.
   always_ff @(posedge CLK) begin
      if (do_write) begin
         mem[idx_eff] <= wd_eff;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_mem_resp.sv
`default_nettype none
// ============================================================================
// tb_mem_resp : randomized and directed checks of two mem_resp instances
// Revision    : 1.0
// ============================================================================
module tb_mem_resp;
   logic CLK = 1'b0;
   logic rst;
   always #5 CLK = ~CLK;

   mem_resp_if if0 ();
   mem_resp_if if1 ();

   mem_resp #(.DEPTH_LOG2(8), .WAIT_CYC(2)) dut0 (.CLK(CLK), .rst(rst), .bus(if0.slave));
   mem_resp #(.DEPTH_LOG2(4), .WAIT_CYC(0)) dut1 (.CLK(CLK), .rst(rst), .bus(if1.slave));

`ifdef MEM_RESP_ALIGN_CHK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   int passed = 0;
   int total  = 0;
   logic [31:0] mdl     [2][256];
   logic [31:0] last_rd [2];
   int depth [2] = '{8, 4};
   int wcyc  [2] = '{2, 0};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic drive(input int d, input logic req, input logic we,
                        input logic [31:0] a, input logic [31:0] wd);
      if (d == 0) begin
         if0.MREQ = req; if0.MWE = we; if0.MRA = a; if0.MWD = wd;
      end else begin
         if1.MREQ = req; if1.MWE = we; if1.MRA = a; if1.MWD = wd;
      end
   endtask

   task automatic sample(input int d, output logic rdy, output logic err, output logic [31:0] rd);
      if (d == 0) begin
         rdy = if0.MRDY; err = if0.MERR; rd = if0.MRD;
      end else begin
         rdy = if1.MRDY; err = if1.MERR; rd = if1.MRD;
      end
   endtask

   // One full transaction checked against the word-array model.
   task automatic xact(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input bit spur, input logic [31:0] sa);
      int          idx;
      int          lat;
      bit          bad;
      logic        rdy;
      logic        err;
      logic [31:0] rd;
      logic [31:0] exp_rd;
      bad = ALIGN && (a[1:0] != 2'b00);
      idx = int'((a >> 2) % (32'd1 << depth[d]));
      @(negedge CLK);
      drive(d, 1'b1, we, a, wd);
      @(posedge CLK);
      #1;
      if (spur) drive(d, 1'b1, 1'b0, sa, 32'h0);
      else      drive(d, 1'b0, we, a, wd);
      lat = 0;
      rdy = 1'b0;
      err = 1'b0;
      rd  = 32'h0;
      while (!rdy && lat < 20) begin
         @(posedge CLK);
         #1;
         lat++;
         if (lat == 1) drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
         sample(d, rdy, err, rd);
      end
      check("latency", 32'(lat), 32'(wcyc[d] + 1));
      check("merr", {31'h0, err}, {31'h0, bad});
      if (we)       exp_rd = last_rd[d];
      else if (bad) exp_rd = 32'h0;
      else          exp_rd = mdl[d][idx];
      check("mrd", rd, exp_rd);
      if (we && !bad) mdl[d][idx] = wd;
      if (!we) last_rd[d] = exp_rd;
      @(posedge CLK);
      #1;
      sample(d, rdy, err, rd);
      check("mrdy_width", {31'h0, rdy}, 32'h0);
   endtask

   task automatic check_idle_outputs(input string tag);
      logic rdy, err;
      logic [31:0] rd;
      for (int d = 0; d < 2; d++) begin
         sample(d, rdy, err, rd);
         check({tag, "_mrdy"}, {31'h0, rdy}, 32'h0);
         check({tag, "_merr"}, {31'h0, err}, 32'h0);
         check({tag, "_mrd"}, rd, 32'h0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      rst = 1'b0;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      #12;
      check_idle_outputs("reset");
      @(negedge CLK);
      rst = 1'b1;

      // Fill every word so every later read has a known expectation.
      for (int i = 0; i < 256; i++) xact(0, 1'b1, 32'(i * 4), $urandom, 1'b0, 32'h0);
      for (int i = 0; i < 16; i++)  xact(1, 1'b1, 32'(i * 4), $urandom, 1'b0, 32'h0);

      xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
      xact(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
      check("deadbeef", last_rd[0], 32'hDEADBEEF);
      xact(1, 1'b1, 32'h0, 32'h12345678, 1'b0, 32'h0);
      xact(1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      check("w0_read", last_rd[1], 32'h12345678);
      xact(0, 1'b1, 32'h400, 32'hA5A5A5A5, 1'b0, 32'h0);
      xact(0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      check("wrap", last_rd[0], 32'hA5A5A5A5);
      xact(0, 1'b1, 32'h44, 32'h0BADF00D, 1'b0, 32'h0);
      xact(0, 1'b0, 32'h44, 32'h0, 1'b1, 32'h10);
      check("spur_ignored", last_rd[0], 32'h0BADF00D);
      xact(1, 1'b0, 32'h8, 32'h0, 1'b1, 32'h0);

      // Reset in the middle of a write's wait states.
      xact(0, 1'b1, 32'h20, 32'h1, 1'b0, 32'h0);
      @(negedge CLK);
      drive(0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF);
      @(negedge CLK);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b0;
      #1;
      check_idle_outputs("rst_wait");
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check_idle_outputs("rst_hold");
      end
      rst = 1'b1;
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      xact(0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
      check("rst_no_write", last_rd[0], 32'h1);

      // Misaligned accesses: flagged and suppressed only when the check is built in.
      xact(0, 1'b1, 32'h22, 32'hCAFEF00D, 1'b0, 32'h0);
      xact(0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
      check("align_word20", last_rd[0], ALIGN ? 32'h1 : 32'hCAFEF00D);
      xact(0, 1'b0, 32'h21, 32'h0, 1'b0, 32'h0);
      xact(1, 1'b0, 32'h5, 32'h0, 1'b0, 32'h0);

      for (int i = 0; i < 120; i++) begin
         a = $urandom & 32'h0000_0FFC;
         if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
         xact(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
              ($urandom_range(0, 7) == 0), $urandom);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
`default_nettype wire
